hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_sb_entry.sv | 35 +++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: producer kinds, forward-select
// encoding and default pipeline latencies.
package hazard_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MUL  = 2'd2,
        KIND_JUMP = 2'd3
    } kind_e;

    // Forward select: 0 reads the register file, value k picks bypass stage k.
    localparam int FWD_SEL_RF = 0;

    localparam int DEFAULT_FWD_DEPTH = 2;
    localparam int DEFAULT_LOAD_LAT  = 1;
    localparam int DEFAULT_MUL_LAT   = 3;

    function automatic int kind_latency(input kind_e kind, input int load_lat, input int mul_lat);
        case (kind)
            KIND_LOAD: return load_lat;
            KIND_MUL:  return mul_lat;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: latency countdown followed by an age walk through the
// bypass stages until the result has drained to the register file.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int FWD_DEPTH = DEFAULT_FWD_DEPTH,
    parameter int LOAD_LAT  = DEFAULT_LOAD_LAT,
    parameter int MUL_LAT   = DEFAULT_MUL_LAT,
    parameter int CW        = 2,
    parameter int AW        = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          set_i,
    input  logic [1:0]    kind_i,
    output logic [CW-1:0] cnt_o,
    output logic [AW-1:0] age_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
            age_o <= '0;
        end else if (set_i) begin
            // Newest writer wins: any older in-flight state is discarded.
            cnt_o <= CW'(kind_latency(kind_e'(kind_i), LOAD_LAT, MUL_LAT));
            age_o <= AW'(1);
        end else if (cnt_o != '0) begin
            cnt_o <= cnt_o - CW'(1);
        end else if (age_o != '0) begin
            age_o <= (age_o >= AW'(FWD_DEPTH)) ? '0 : age_o + AW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: stall and bypass-select generation for decode.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int FWD_DEPTH = DEFAULT_FWD_DEPTH,
    parameter int LOAD_LAT  = DEFAULT_LOAD_LAT,
    parameter int MUL_LAT   = DEFAULT_MUL_LAT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           issue_valid_i,
    input  logic [$clog2(NREG)-1:0]        issue_rs1_i,
    input  logic [$clog2(NREG)-1:0]        issue_rs2_i,
    input  logic                           issue_use_rs1_i,
    input  logic                           issue_use_rs2_i,
    input  logic [$clog2(NREG)-1:0]        issue_rd_i,
    input  logic                           issue_wr_i,
    input  logic [1:0]                     issue_kind_i,
    input  logic                           flush_i,
    output logic                           stall_o,
    output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_rs1_sel_o,
    output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_rs2_sel_o,
    output logic [NREG-1:0]                pending_o,
    output logic [31:0]                    perf_stall_cnt_o
);

    localparam int RW      = $clog2(NREG);
    localparam int SW      = $clog2(FWD_DEPTH + 1);
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int CW      = ($clog2(MAX_LAT + 1) < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt [NREG];
    logic [SW-1:0] age [NREG];
    logic          accept;
    logic          rs1_busy;
    logic          rs2_busy;

    // Handshake: decode holds an instruction while issue_valid_i=1; it is taken
    // on the rising edge where stall_o=0 and flush_i=0, otherwise it must stay put.
    assign accept = issue_valid_i && !stall_o && !flush_i;

    assign cnt[0]       = '0;
    assign age[0]       = '0;
    assign pending_o[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        hazard_sb_entry #(
            .FWD_DEPTH (FWD_DEPTH),
            .LOAD_LAT  (LOAD_LAT),
            .MUL_LAT   (MUL_LAT),
            .CW        (CW),
            .AW        (SW)
        ) u_entry (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .set_i  (accept && issue_wr_i && (issue_rd_i == RW'(r))),
            .kind_i (issue_kind_i),
            .cnt_o  (cnt[r]),
            .age_o  (age[r])
        );
        assign pending_o[r] = (age[r] != '0);
    end

    assign rs1_busy = issue_use_rs1_i && (issue_rs1_i != '0) && (cnt[issue_rs1_i] != '0);
    assign rs2_busy = issue_use_rs2_i && (issue_rs2_i != '0) && (cnt[issue_rs2_i] != '0);
    // A squash wins over a hazard: the held instruction simply disappears.
    assign stall_o  = issue_valid_i && !flush_i && (rs1_busy || rs2_busy);

    always_comb begin
        fwd_rs1_sel_o = SW'(FWD_SEL_RF);
        fwd_rs2_sel_o = SW'(FWD_SEL_RF);
        if ((issue_rs1_i != '0) && (cnt[issue_rs1_i] == '0)) begin
            fwd_rs1_sel_o = age[issue_rs1_i];
        end
        if ((issue_rs2_i != '0) && (cnt[issue_rs2_i] == '0)) begin
            fwd_rs2_sel_o = age[issue_rs2_i];
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (stall_o) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = '0;
`endif

endmodule
